// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage pipeline and alu_mdu.
// The master drives operands and control; the slave returns the result, HI/LO and handshake.
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_ctrl;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [SHW-1:0]   shamt;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_ctrl, data1, data2, shamt, flush,
        input  in_ready, out_valid, alu_res, zero, hi, lo
    );

    modport slave (
        input  in_valid, alu_ctrl, data1, data2, shamt, flush,
        output in_ready, out_valid, alu_res, zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered result, plus an iterative multiply/divide unit owning HI/LO.
// Single-cycle ops finish at the accept edge; MULT/DIV take WIDTH edges with in_ready held low.
module alu_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    localparam logic [4:0] OpAdd  = 5'd1;
    localparam logic [4:0] OpSub  = 5'd2;
    localparam logic [4:0] OpAnd  = 5'd3;
    localparam logic [4:0] OpOr   = 5'd4;
    localparam logic [4:0] OpXor  = 5'd5;
    localparam logic [4:0] OpLui  = 5'd6;
    localparam logic [4:0] OpSlt  = 5'd7;
    localparam logic [4:0] OpSll  = 5'd8;
    localparam logic [4:0] OpSrl  = 5'd9;
    localparam logic [4:0] OpSra  = 5'd10;
    localparam logic [4:0] OpSltu = 5'd11;
    localparam logic [4:0] OpNor  = 5'd12;
    localparam logic [4:0] OpMult = 5'd16;
    localparam logic [4:0] OpMulu = 5'd17;
    localparam logic [4:0] OpDiv  = 5'd18;
    localparam logic [4:0] OpDivu = 5'd19;
    localparam logic [4:0] OpMfhi = 5'd20;
    localparam logic [4:0] OpMflo = 5'd21;

    localparam logic [SHW-1:0] CntInit = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e             r_state, w_state_d;
    logic               r_out_valid, w_out_valid_d;
    logic [WIDTH-1:0]   r_alu_res, w_alu_res_d;
    logic               r_zero, w_zero_d;
    logic [WIDTH-1:0]   r_hi, w_hi_d;
    logic [WIDTH-1:0]   r_lo, w_lo_d;
    logic [SHW-1:0]     r_cnt, w_cnt_d;
    logic [WIDTH-1:0]   r_a, w_a_d;
    logic [WIDTH-1:0]   r_b, w_b_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic               r_neg_q, w_neg_q_d;
    logic               r_neg_r, w_neg_r_d;

    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_lui;
    logic               w_signed;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_q_step;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // Narrow builds have no 16-bit immediate field; use the low half instead.
    if (WIDTH > 16) begin : g_lui_wide
        assign w_lui = {bus.data2[15:0], {(WIDTH-16){1'b0}}};
    end else if (WIDTH == 16) begin : g_lui_16
        assign w_lui = bus.data2;
    end else begin : g_lui_narrow
        assign w_lui = {bus.data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
    end

    always_comb begin
        w_alu = '0;
        case (bus.alu_ctrl)
            OpAdd:   w_alu = bus.data1 + bus.data2;
            OpSub:   w_alu = bus.data1 - bus.data2;
            OpAnd:   w_alu = bus.data1 & bus.data2;
            OpOr:    w_alu = bus.data1 | bus.data2;
            OpXor:   w_alu = bus.data1 ^ bus.data2;
            OpLui:   w_alu = w_lui;
            OpSlt:   w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
            OpSll:   w_alu = bus.data1 << bus.shamt;
            OpSrl:   w_alu = bus.data1 >> bus.shamt;
            OpSra:   w_alu = $unsigned($signed(bus.data1) >>> bus.shamt);
            OpSltu:  w_alu = {{(WIDTH-1){1'b0}}, bus.data1 < bus.data2};
            OpNor:   w_alu = ~(bus.data1 | bus.data2);
            OpMfhi:  w_alu = r_hi;
            OpMflo:  w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    assign w_signed = (bus.alu_ctrl == OpMult) || (bus.alu_ctrl == OpDiv);

    // Shift-add multiply: add into the upper half, then shift the whole product right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod    = r_neg_q ? -w_mul_acc : w_mul_acc;

    // Restoring divide: remainder in r_acc upper half, dividend/quotient shifts through r_b.
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_b[WIDTH-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_a};
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_a;
    assign w_rem_step = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
    assign w_q_step   = {r_b[WIDTH-2:0], w_div_ge};
    assign w_quot     = r_neg_q ? -w_q_step : w_q_step;
    assign w_rem      = r_neg_r ? -w_rem_step : w_rem_step;

    always_comb begin
        w_state_d     = r_state;
        w_out_valid_d = 1'b0;
        w_alu_res_d   = r_alu_res;
        w_zero_d      = r_zero;
        w_hi_d        = r_hi;
        w_lo_d        = r_lo;
        w_cnt_d       = r_cnt;
        w_a_d         = r_a;
        w_b_d         = r_b;
        w_acc_d       = r_acc;
        w_neg_q_d     = r_neg_q;
        w_neg_r_d     = r_neg_r;

        if (bus.flush) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        case (bus.alu_ctrl)
                            OpMult, OpMulu: begin
                                w_a_d     = mag(bus.data1, w_signed);
                                w_b_d     = mag(bus.data2, w_signed);
                                w_neg_q_d = w_signed & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                                w_acc_d   = '0;
                                w_cnt_d   = CntInit;
                                w_state_d = StMul;
                            end
                            OpDiv, OpDivu: begin
                                if (bus.data2 == '0) begin
                                    w_lo_d        = '1;
                                    w_hi_d        = bus.data1;
                                    w_alu_res_d   = '1;
                                    w_zero_d      = 1'b0;
                                    w_out_valid_d = 1'b1;
                                end else begin
                                    w_a_d     = mag(bus.data2, w_signed);
                                    w_b_d     = mag(bus.data1, w_signed);
                                    w_neg_q_d = w_signed & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
                                    w_neg_r_d = w_signed & bus.data1[WIDTH-1];
                                    w_acc_d   = '0;
                                    w_cnt_d   = CntInit;
                                    w_state_d = StDiv;
                                end
                            end
                            default: begin
                                w_alu_res_d   = w_alu;
                                w_zero_d      = (w_alu == '0);
                                w_out_valid_d = 1'b1;
                            end
                        endcase
                    end
                end
                StMul: begin
                    w_acc_d = w_mul_acc;
                    w_b_d   = r_b >> 1;
                    w_cnt_d = r_cnt - SHW'(1);
                    if (r_cnt == '0) begin
                        w_hi_d        = w_prod[2*WIDTH-1:WIDTH];
                        w_lo_d        = w_prod[WIDTH-1:0];
                        w_alu_res_d   = w_prod[WIDTH-1:0];
                        w_zero_d      = (w_prod[WIDTH-1:0] == '0);
                        w_out_valid_d = 1'b1;
                        w_cnt_d       = '0;
                        w_state_d     = StIdle;
                    end
                end
                StDiv: begin
                    w_acc_d = {w_rem_step, r_acc[WIDTH-1:0]};
                    w_b_d   = w_q_step;
                    w_cnt_d = r_cnt - SHW'(1);
                    if (r_cnt == '0) begin
                        w_hi_d        = w_rem;
                        w_lo_d        = w_quot;
                        w_alu_res_d   = w_quot;
                        w_zero_d      = (w_quot == '0);
                        w_out_valid_d = 1'b1;
                        w_cnt_d       = '0;
                        w_state_d     = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_alu_res   <= '0;
            r_zero      <= 1'b1;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_out_valid <= w_out_valid_d;
            r_alu_res   <= w_alu_res_d;
            r_zero      <= w_zero_d;
            r_hi        <= w_hi_d;
            r_lo        <= w_lo_d;
            r_cnt       <= w_cnt_d;
            r_a         <= w_a_d;
            r_b         <= w_b_d;
            r_acc       <= w_acc_d;
            r_neg_q     <= w_neg_q_d;
            r_neg_r     <= w_neg_r_d;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = r_out_valid;
    assign bus.alu_res   = r_alu_res;
    assign bus.zero      = r_zero;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit instance for the main sequence, an 8-bit one for the narrow build.
module tb_alu_mdu;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   lat;
    logic rdy;

    alu_mdu_if #(.WIDTH(32)) bus32 ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_mdu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit bus; returns edges from accept to out_valid and in_ready after accept.
    task automatic run_op(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] sh, output int l, output logic r);
        bus32.alu_ctrl = op;
        bus32.data1    = d1;
        bus32.data2    = d2;
        bus32.shamt    = sh;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        r = bus32.in_ready;
        l = 0;
        while (!bus32.out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run_op8(input logic [4:0] op, input logic [7:0] d1, input logic [7:0] d2,
                           output int l);
        bus8.alu_ctrl = op;
        bus8.data1    = d1;
        bus8.data2    = d2;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        l = 0;
        while (!bus8.out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus32.in_valid = 1'b0; bus32.alu_ctrl = '0; bus32.data1 = '0; bus32.data2 = '0;
        bus32.shamt = '0; bus32.flush = 1'b0;
        bus8.in_valid = 1'b0; bus8.alu_ctrl = '0; bus8.data1 = '0; bus8.data2 = '0;
        bus8.shamt = '0; bus8.flush = 1'b0;

        // Asynchronous reset asserted mid-cycle
        #13 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus32.out_valid), 32'd0);
        chk("rst_hi", bus32.hi, 32'd0);
        chk("rst_lo", bus32.lo, 32'd0);
        chk("rst_zero", 32'(bus32.zero), 32'd1);
        chk("rst_alu_res", bus32.alu_res, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus32.in_ready), 32'd1);

        run_op(5'd1, 32'd5, 32'd7, 5'd0, lat, rdy);
        chk("add_lat", lat, 32'd0);
        chk("add_res", bus32.alu_res, 32'd12);
        chk("add_zero", 32'(bus32.zero), 32'd0);
        run_op(5'd2, 32'd7, 32'd7, 5'd0, lat, rdy);
        chk("sub_lat", lat, 32'd0);
        chk("sub_res", bus32.alu_res, 32'd0);
        chk("sub_zero", 32'(bus32.zero), 32'd1);
        @(posedge clk); #1;
        chk("pulse_one_cycle", 32'(bus32.out_valid), 32'd0);
        chk("res_held", bus32.alu_res, 32'd0);

        // Compare, shift, logic
        run_op(5'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, rdy);
        chk("slt", bus32.alu_res, 32'd1);
        run_op(5'd11, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, rdy);
        chk("sltu", bus32.alu_res, 32'd0);
        chk("sltu_zero", 32'(bus32.zero), 32'd1);
        run_op(5'd10, 32'h8000_0000, 32'd0, 5'd4, lat, rdy);
        chk("sra", bus32.alu_res, 32'hF800_0000);
        run_op(5'd9, 32'h8000_0000, 32'd0, 5'd4, lat, rdy);
        chk("srl", bus32.alu_res, 32'h0800_0000);
        run_op(5'd8, 32'd3, 32'd0, 5'd4, lat, rdy);
        chk("sll", bus32.alu_res, 32'h0000_0030);
        run_op(5'd6, 32'd0, 32'h0000_1234, 5'd0, lat, rdy);
        chk("lui", bus32.alu_res, 32'h1234_0000);
        run_op(5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, rdy);
        chk("and", bus32.alu_res, 32'hF000_F000);
        run_op(5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, rdy);
        chk("or", bus32.alu_res, 32'hFFF0_FFF0);
        run_op(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, rdy);
        chk("xor", bus32.alu_res, 32'h0FF0_0FF0);
        run_op(5'd12, 32'd0, 32'd0, 5'd0, lat, rdy);
        chk("nor", bus32.alu_res, 32'hFFFF_FFFF);
        run_op(5'd31, 32'd9, 32'd9, 5'd0, lat, rdy);
        chk("bad_op_lat", lat, 32'd0);
        chk("bad_op_res", bus32.alu_res, 32'd0);
        chk("single_keeps_hi", bus32.hi, 32'd0);
        chk("single_keeps_lo", bus32.lo, 32'd0);

        // Signed multiply
        run_op(5'd16, 32'hFFFF_FFFD, 32'd7, 5'd0, lat, rdy);
        chk("mult_busy", 32'(rdy), 32'd0);
        chk("mult_lat", lat, 32'd32);
        chk("mult_hi", bus32.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus32.lo, 32'hFFFF_FFEB);
        chk("mult_res", bus32.alu_res, 32'hFFFF_FFEB);

        // MULTU with an ADD request held during the iteration; it must be dropped
        bus32.alu_ctrl = 5'd17; bus32.data1 = 32'hFFFF_FFFF; bus32.data2 = 32'd2;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.alu_ctrl = 5'd1; bus32.data1 = 32'd1; bus32.data2 = 32'd1;
        lat = 0;
        while (!bus32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) bus32.in_valid = 1'b0;
        end
        chk("multu_lat", lat, 32'd32);
        chk("multu_hi", bus32.hi, 32'd1);
        chk("multu_lo", bus32.lo, 32'hFFFF_FFFE);
        chk("multu_res", bus32.alu_res, 32'hFFFF_FFFE);
        run_op(5'd20, 32'd0, 32'd0, 5'd0, lat, rdy);
        chk("mfhi_lat", lat, 32'd0);
        chk("mfhi", bus32.alu_res, 32'd1);
        run_op(5'd21, 32'd0, 32'd0, 5'd0, lat, rdy);
        chk("mflo", bus32.alu_res, 32'hFFFF_FFFE);

        // Divide
        run_op(5'd18, 32'hFFFF_FFF9, 32'd2, 5'd0, lat, rdy);
        chk("div_lat", lat, 32'd32);
        chk("div_lo", bus32.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus32.hi, 32'hFFFF_FFFF);
        run_op(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, lat, rdy);
        chk("div_ovf_lo", bus32.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus32.hi, 32'd0);
        run_op(5'd19, 32'd100, 32'd7, 5'd0, lat, rdy);
        chk("divu_lo", bus32.lo, 32'd14);
        chk("divu_hi", bus32.hi, 32'd2);
        run_op(5'd19, 32'hFFFF_FFFF, 32'h10, 5'd0, lat, rdy);
        chk("divu_big_lo", bus32.lo, 32'h0FFF_FFFF);
        chk("divu_big_hi", bus32.hi, 32'h0000_000F);
        run_op(5'd19, 32'd9, 32'd0, 5'd0, lat, rdy);
        chk("div0_lat", lat, 32'd0);
        chk("div0_ready", 32'(rdy), 32'd1);
        chk("div0_lo", bus32.lo, 32'hFFFF_FFFF);
        chk("div0_hi", bus32.hi, 32'd9);
        chk("div0_res", bus32.alu_res, 32'hFFFF_FFFF);

        // Flush a divide part way through
        bus32.alu_ctrl = 5'd18; bus32.data1 = 32'd1000; bus32.data2 = 32'd3;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        chk("flush_idle", 32'(bus32.in_ready), 32'd1);
        chk("flush_no_valid", 32'(bus32.out_valid), 32'd0);
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.out_valid) lat++;
        end
        chk("flush_no_late_pulse", lat, 32'd0);
        chk("flush_keeps_hi", bus32.hi, 32'd9);
        chk("flush_keeps_lo", bus32.lo, 32'hFFFF_FFFF);
        run_op(5'd1, 32'd2, 32'd3, 5'd0, lat, rdy);
        chk("post_flush_add", bus32.alu_res, 32'd5);

        // Flush wins over a simultaneous accept
        bus32.alu_ctrl = 5'd1; bus32.data1 = 32'd1; bus32.data2 = 32'd1;
        bus32.in_valid = 1'b1; bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0; bus32.flush = 1'b0;
        chk("flush_accept_valid", 32'(bus32.out_valid), 32'd0);
        chk("flush_accept_res", bus32.alu_res, 32'd5);

        // Reset in the middle of a multiply
        bus32.alu_ctrl = 5'd16; bus32.data1 = 32'd123; bus32.data2 = 32'd456;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus32.in_ready), 32'd1);
        chk("midrst_hi", bus32.hi, 32'd0);
        chk("midrst_lo", bus32.lo, 32'd0);
        chk("midrst_zero", 32'(bus32.zero), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(5'd1, 32'd4, 32'd4, 5'd0, lat, rdy);
        chk("midrst_add", bus32.alu_res, 32'd8);

        // Narrow build
        run_op8(5'd16, 8'h80, 8'h80, lat);
        chk("w8_mult_lat", lat, 32'd8);
        chk("w8_mult_hi", 32'(bus8.hi), 32'h40);
        chk("w8_mult_lo", 32'(bus8.lo), 32'h00);
        chk("w8_mult_zero", 32'(bus8.zero), 32'd1);
        run_op8(5'd18, 8'h80, 8'hFF, lat);
        chk("w8_div_ovf_lo", 32'(bus8.lo), 32'h80);
        chk("w8_div_ovf_hi", 32'(bus8.hi), 32'h00);
        run_op8(5'd19, 8'd200, 8'd10, lat);
        chk("w8_divu_lo", 32'(bus8.lo), 32'd20);
        chk("w8_divu_hi", 32'(bus8.hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
